vending_change_dispenser: RTL and testbench

//  Pays out change, in nickels and dimes, through the coin-hopper eject interface.

---
 rtl/vending_change_dispenser.sv | 146 ++++++++++++++
 tb/tb_vending_change_dispenser.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_change_dispenser.sv
// ---------------------------------------------------------------------------
// vending_change_dispenser: greedy dime/nickel change payout with inventory.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vending_change_dispenser #(
  parameter int AMT_W  = 8,
  parameter int CNT_W  = 8,
  parameter int N_INIT = 20,
  parameter int D_INIT = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic             coin_n,
  output logic             coin_d,
  input  logic             coin_ack,
  input  logic             refill_n,
  input  logic             refill_d,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] shortfall,
  output logic [CNT_W-1:0] n_count,
  output logic [CNT_W-1:0] d_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);
  localparam logic [AMT_W-1:0] AMT_TWO = AMT_W'(2);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] N_RST   = CNT_W'(N_INIT);
  localparam logic [CNT_W-1:0] D_RST   = CNT_W'(D_INIT);

  state_t           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             coin_n_q, coin_n_d;
  logic             coin_d_q, coin_d_d;
  logic             done_q, done_d;
  logic [AMT_W-1:0] shortfall_q, shortfall_d;
  logic [CNT_W-1:0] n_count_q, n_count_d;
  logic [CNT_W-1:0] d_count_q, d_count_d;
  logic             n_dec, d_dec;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    coin_n_d    = coin_n_q;
    coin_d_d    = coin_d_q;
    done_d      = 1'b0;
    shortfall_d = shortfall_q;
    n_dec       = 1'b0;
    d_dec       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rem_d   = req_amount;
          state_d = SEL;
        end
      end
      SEL: begin
        // Odd remainders never fall back to a dime: no overpaying.
        if (rem_q >= AMT_TWO && d_count_q != '0) begin
          coin_d_d = 1'b1;
          state_d  = WAIT;
        end else if (rem_q >= AMT_ONE && n_count_q != '0) begin
          coin_n_d = 1'b1;
          state_d  = WAIT;
        end else begin
          done_d      = 1'b1;
          shortfall_d = rem_q;
          state_d     = IDLE;
        end
      end
      WAIT: begin
        if (coin_ack) begin
          n_dec    = coin_n_q;
          d_dec    = coin_d_q;
          rem_d    = rem_q - (coin_d_q ? AMT_TWO : AMT_ONE);
          coin_n_d = 1'b0;
          coin_d_d = 1'b0;
          state_d  = SEL;
        end
      end
      default: state_d = IDLE;
    endcase

    // A refill landing on the same edge as a payout cancels it out.
    n_count_d = n_count_q;
    case ({refill_n, n_dec})
      2'b10:   if (n_count_q != CNT_MAX) n_count_d = n_count_q + CNT_ONE;
      2'b01:   n_count_d = n_count_q - CNT_ONE;
      default: n_count_d = n_count_q;
    endcase

    d_count_d = d_count_q;
    case ({refill_d, d_dec})
      2'b10:   if (d_count_q != CNT_MAX) d_count_d = d_count_q + CNT_ONE;
      2'b01:   d_count_d = d_count_q - CNT_ONE;
      default: d_count_d = d_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      coin_n_q    <= 1'b0;
      coin_d_q    <= 1'b0;
      done_q      <= 1'b0;
      shortfall_q <= '0;
      n_count_q   <= N_RST;
      d_count_q   <= D_RST;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      coin_n_q    <= coin_n_d;
      coin_d_q    <= coin_d_d;
      done_q      <= done_d;
      shortfall_q <= shortfall_d;
      n_count_q   <= n_count_d;
      d_count_q   <= d_count_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = !req_ready;
  assign coin_n    = coin_n_q;
  assign coin_d    = coin_d_q;
  assign done      = done_q;
  assign shortfall = shortfall_q;
  assign n_count   = n_count_q;
  assign d_count   = d_count_q;

endmodule

`default_nettype wire

// File: tb/tb_vending_change_dispenser.sv
// ---------------------------------------------------------------------------
// tb_vending_change_dispenser: table-driven bench with a coin scoreboard.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vending_change_dispenser;

  logic       clk;
  logic       rstn;
  logic       req_valid;
  logic [7:0] req_amount;
  logic       req_ready;
  logic       coin_n;
  logic       coin_d;
  logic       coin_ack;
  logic       refill_n;
  logic       refill_d;
  logic       busy;
  logic       done;
  logic [7:0] shortfall;
  logic [7:0] n_count;
  logic [7:0] d_count;

  vending_change_dispenser #(
    .AMT_W (8),
    .CNT_W (8),
    .N_INIT(20),
    .D_INIT(10)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_amount(req_amount),
    .req_ready (req_ready),
    .coin_n    (coin_n),
    .coin_d    (coin_d),
    .coin_ack  (coin_ack),
    .refill_n  (refill_n),
    .refill_d  (refill_d),
    .busy      (busy),
    .done      (done),
    .shortfall (shortfall),
    .n_count   (n_count),
    .d_count   (d_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] amt;
    int         delay;
    int         pre_rd;
    logic [7:0] sf;
    logic [7:0] n;
    logic [7:0] d;
  } vec_t;

  vec_t vecs[11];
  bit   exp_q[$];     // 1 = dime expected, 0 = nickel expected
  int   checks;
  int   failures;
  int   m_n;
  int   m_d;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input logic [7:0] amt, input int delay, input int pre_rd,
                         input bit refill_on_ack, input logic [7:0] exp_sf,
                         input logic [7:0] exp_n, input logic [7:0] exp_d,
                         input string nm);
    int  rem;
    int  held;
    bit  got_done;
    bit  want;
    for (int i = 0; i < pre_rd; i++) begin
      refill_d = 1'b1;
      tick();
      refill_d = 1'b0;
      if (m_d < 255) m_d++;
    end
    rem = amt;
    forever begin
      if (rem >= 2 && m_d > 0) begin
        exp_q.push_back(1'b1); m_d--; rem -= 2;
      end else if (rem >= 1 && m_n > 0) begin
        exp_q.push_back(1'b0); rem -= 1;
        if (!refill_on_ack) m_n--;
      end else break;
    end
    check({nm, "_ready"}, req_ready, 1);
    req_valid  = 1'b1;
    req_amount = amt;
    tick();
    req_valid = 1'b0;
    held      = 0;
    got_done  = 1'b0;
    for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
      coin_ack = 1'b0;
      refill_n = 1'b0;
      if (coin_n && coin_d) check({nm, "_coin_excl"}, 1, 0);
      if (coin_n || coin_d) begin
        if (held == 0) begin
          if (exp_q.size() == 0) check({nm, "_extra_coin"}, 1, 0);
          else begin
            want = exp_q.pop_front();
            check({nm, "_coin_type"}, coin_d, want);
          end
        end
        held++;
        if (held == delay + 1) begin
          coin_ack = 1'b1;
          if (refill_on_ack) refill_n = 1'b1;
        end
      end else if (held > 0) begin
        check({nm, "_hold_len"}, held, delay + 1);
        held = 0;
      end
      if (done) begin
        got_done = 1'b1;
        check({nm, "_shortfall"}, shortfall, exp_sf);
        check({nm, "_n_count"}, n_count, exp_n);
        check({nm, "_d_count"}, d_count, exp_d);
        check({nm, "_coins_left"}, exp_q.size(), 0);
        exp_q.delete();
      end else begin
        tick();
      end
    end
    coin_ack = 1'b0;
    refill_n = 1'b0;
    if (!got_done) check({nm, "_timeout"}, 1, 0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    m_n        = 20;
    m_d        = 10;
    rstn       = 1'b0;
    req_valid  = 1'b0;
    req_amount = '0;
    coin_ack   = 1'b0;
    refill_n   = 1'b0;
    refill_d   = 1'b0;

    //        amt    dly pre_rd sf     n       d
    vecs[0]  = '{8'd3,  0, 0, 8'd0, 8'd19, 8'd8};
    vecs[1]  = '{8'd0,  0, 0, 8'd0, 8'd19, 8'd8};
    vecs[2]  = '{8'd2,  3, 0, 8'd0, 8'd19, 8'd7};
    vecs[3]  = '{8'd14, 1, 0, 8'd0, 8'd19, 8'd0};
    vecs[4]  = '{8'd4,  0, 0, 8'd0, 8'd15, 8'd0};
    vecs[5]  = '{8'd5,  2, 0, 8'd0, 8'd10, 8'd0};
    vecs[6]  = '{8'd10, 0, 0, 8'd0, 8'd0,  8'd0};
    vecs[7]  = '{8'd5,  0, 2, 8'd1, 8'd0,  8'd0};
    vecs[8]  = '{8'd3,  0, 0, 8'd3, 8'd0,  8'd0};
    vecs[9]  = '{8'd1,  0, 1, 8'd1, 8'd0,  8'd1};
    vecs[10] = '{8'd2,  0, 0, 8'd0, 8'd0,  8'd0};

    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_coins", {coin_n, coin_d}, 0);
    check("rst_done", done, 0);
    check("rst_shortfall", shortfall, 0);
    check("rst_n_count", n_count, 20);
    check("rst_d_count", d_count, 10);

    // Zero-amount request: done exactly two cycles after the accept cycle.
    req_valid  = 1'b1;
    req_amount = 8'd0;
    tick();
    req_valid = 1'b0;
    check("zero_busy", busy, 1);
    check("zero_done_early", done, 0);
    tick();
    check("zero_done", done, 1);
    check("zero_shortfall", shortfall, 0);
    check("zero_ready", req_ready, 1);
    check("zero_coins", {coin_n, coin_d}, 0);
    tick();
    check("zero_done_pulse", done, 0);

    // Request of 2 with req_valid re-asserted while busy.
    req_valid  = 1'b1;
    req_amount = 8'd2;
    tick();
    req_amount = 8'd5;
    check("busyreq_busy", busy, 1);
    tick();
    check("busyreq_coin_d", coin_d, 1);
    check("busyreq_coin_n", coin_n, 0);
    coin_ack = 1'b1;
    tick();
    coin_ack  = 1'b0;
    req_valid = 1'b0;
    check("busyreq_busy_sel", busy, 1);
    tick();
    check("busyreq_done", done, 1);
    check("busyreq_shortfall", shortfall, 0);
    check("busyreq_d_count", d_count, 9);
    m_d = 9;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("busyreq_idle_coins", {coin_n, coin_d}, 0);
      check("busyreq_idle_done", done, 0);
    end

    for (int v = 0; v < 11; v++)
      run_req(vecs[v].amt, vecs[v].delay, vecs[v].pre_rd, 1'b0,
              vecs[v].sf, vecs[v].n, vecs[v].d, $sformatf("vec%0d", v));

    // Saturating refill: 256 nickel pulses from empty, plus 3 dimes.
    for (int i = 0; i < 256; i++) begin
      refill_n = 1'b1;
      refill_d = (i < 3);
      tick();
    end
    refill_n = 1'b0;
    refill_d = 1'b0;
    check("sat_n_count", n_count, 255);
    check("sat_d_count", d_count, 3);
    m_n = 255;
    m_d = 3;

    run_req(8'd1, 0, 0, 1'b1, 8'd0, 8'd255, 8'd3, "refack_sat");
    run_req(8'd1, 0, 0, 1'b0, 8'd0, 8'd254, 8'd3, "nickel_plain");
    run_req(8'd1, 1, 0, 1'b1, 8'd0, 8'd254, 8'd3, "refack_mid");

    // Reset while a dime is waiting for its ack.
    req_valid  = 1'b1;
    req_amount = 8'd2;
    tick();
    req_valid = 1'b0;
    tick();
    check("rstwait_coin_d", coin_d, 1);
    tick();
    rstn = 1'b0;
    tick();
    check("rstwait_coins", {coin_n, coin_d}, 0);
    check("rstwait_done", done, 0);
    check("rstwait_n_count", n_count, 20);
    check("rstwait_d_count", d_count, 10);
    check("rstwait_ready", req_ready, 1);
    rstn = 1'b1;
    tick();
    check("rstwait_no_done", done, 0);
    check("rstwait_ready2", req_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
